keypad_encoder: RTL and testbench

Upstream front end of synth_top. Takes the 15 raw, asynchronous, bouncing keypad buttons and produces clean, debounced outputs for the downstream stages:
- a 4-bit note keycode for frequency_divider
- a one-cycle new-note strobe
- one-cycle pulses for the mode key (to mode_fsm) and the sound-series key (to the sound series FSM)

---
 rtl/keypad_encoder.sv | 129 ++++++++++++
 tb/tb_keypad_encoder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_encoder.sv
// keypad_encoder
//   Front end of the synthesizer. Synchronizes 15 raw, bouncing keypad
//   buttons and produces debounced, glitch-free outputs for the later stages.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   keypad_i     raw buttons, active-high.
//                [12:0] are the note keys, [13] is the mode key,
//                [14] is the series key.
//   keycode      debounced note code.
//                0 = no note; 1..13 = keypad_i[0..12], lowest index wins.
//   note_strobe  one-cycle pulse when keycode takes a new nonzero value
//   mode_key     one-cycle pulse on a debounced press of keypad_i[13]
//   series_key   one-cycle pulse on a debounced press of keypad_i[14]
//
// Every output comes straight from a flop, so there is no combinational
// path from keypad_i to any output.
module keypad_encoder #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int CNT_W           = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] keypad_i,
    output logic [3:0]  keycode,
    output logic        note_strobe,
    output logic        mode_key,
    output logic        series_key
);

    // A candidate is accepted once the counter has reached this value while
    // the raw input has matched the candidate on every cycle.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [14:0]      sync1_r;
    logic [14:0]      sync2_r;
    logic [3:0]       raw_s;
    logic [3:0]       cand_r;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       stable_r;
    logic             strobe_r;

    // Index 0 is the mode key and index 1 is the series key.
    logic [1:0]       ctl_cand_r;
    logic [CNT_W-1:0] ctl_cnt_r [2];
    logic [1:0]       ctl_stable_r;
    logic [1:0]       ctl_pulse_r;

    // Priority encoder: 1 + the lowest set index, or 0 if no bit is set.
    // The scan runs from the top index downward, so the lowest set index is
    // the last one written and therefore wins.
    function automatic logic [3:0] encode_note(input logic [12:0] bits);
        logic [3:0] code;
        code = 4'd0;
        for (int i = 12; i >= 0; i--) begin
            if (bits[i]) begin
                code = 4'(i + 1);
            end
        end
        return code;
    endfunction

    assign raw_s = encode_note(sync2_r[12:0]);

    // Synchronizers, the note debounce path, and the note strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r  <= 15'd0;
            sync2_r  <= 15'd0;
            cand_r   <= 4'd0;
            cnt_r    <= '0;
            stable_r <= 4'd0;
            strobe_r <= 1'b0;
        end else begin
            sync1_r  <= keypad_i;
            sync2_r  <= sync1_r;
            strobe_r <= 1'b0;
            if (raw_s != cand_r) begin
                // A new raw value restarts the hold count.
                cand_r <= raw_s;
                cnt_r  <= '0;
            end else if (cnt_r == LAST) begin
                // The counter saturates here. Stable is updated only when the
                // candidate differs, so a held key updates stable just once.
                if (cand_r != stable_r) begin
                    stable_r <= cand_r;
                    strobe_r <= (cand_r != 4'd0);
                end
            end else begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Control keys: each has its own 1-bit debounce and a rising-edge pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctl_cand_r   <= 2'b00;
            ctl_stable_r <= 2'b00;
            ctl_pulse_r  <= 2'b00;
            for (int j = 0; j < 2; j++) begin
                ctl_cnt_r[j] <= '0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                ctl_pulse_r[j] <= 1'b0;
                if (sync2_r[13+j] != ctl_cand_r[j]) begin
                    ctl_cand_r[j] <= sync2_r[13+j];
                    ctl_cnt_r[j]  <= '0;
                end else if (ctl_cnt_r[j] == LAST) begin
                    if (ctl_cand_r[j] != ctl_stable_r[j]) begin
                        ctl_stable_r[j] <= ctl_cand_r[j];
                        // Only the 0 -> 1 transition (a press) gives a pulse.
                        ctl_pulse_r[j]  <= ctl_cand_r[j];
                    end
                end else begin
                    ctl_cnt_r[j] <= ctl_cnt_r[j] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign keycode     = stable_r;
    assign note_strobe = strobe_r;
    assign mode_key    = ctl_pulse_r[0];
    assign series_key  = ctl_pulse_r[1];

endmodule

// File: tb/tb_keypad_encoder.sv
// Testbench for keypad_encoder with DEBOUNCE_CYCLES = 4.
// The reference model works from input history. A debounced value is
// accepted once the synchronized encoded value has been seen on D+1
// consecutive clock edges. The reset edge counts as a sample of 0.
module tb_keypad_encoder;

    localparam int D = 4;

    logic        clk;
    logic        reset;
    logic [14:0] keypad_i;
    logic [3:0]  keycode;
    logic        note_strobe;
    logic        mode_key;
    logic        series_key;

    int checks = 0;
    int errors = 0;

    // Observed pulse counts. Directed sections reset and then inspect these.
    int n_strobe = 0;
    int n_mode   = 0;
    int n_series = 0;
    int n_both   = 0;

    // Reference model state.
    logic [14:0] m_d1;
    logic [14:0] m_d2;
    logic [3:0]  m_last;
    int          m_run;
    logic [3:0]  m_stable;
    logic [1:0]  c_last;
    int          c_run [2];
    logic [1:0]  c_stable;
    logic [3:0]  exp_keycode;
    logic        exp_strobe;
    logic [1:0]  exp_ctl;

    keypad_encoder #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .keypad_i   (keypad_i),
        .keycode    (keycode),
        .note_strobe(note_strobe),
        .mode_key   (mode_key),
        .series_key (series_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Note code from the spec rule: 1 + the lowest set note index, else 0.
    function automatic logic [3:0] ref_enc(input logic [14:0] k);
        for (int i = 0; i < 13; i++) begin
            if (k[i]) return 4'(i + 1);
        end
        return 4'd0;
    endfunction

    // Advance the model by one clock edge.
    // m_d1 and m_d2 hold the inputs sampled one and two edges ago.
    task automatic model_edge(input logic [14:0] k, input logic r);
        logic [3:0] rv;
        logic [1:0] rc;
        if (r) begin
            m_d1 = 15'd0;
            m_d2 = 15'd0;
            m_last = 4'd0;
            m_run = 1;
            m_stable = 4'd0;
            c_last = 2'b00;
            c_run[0] = 1;
            c_run[1] = 1;
            c_stable = 2'b00;
            exp_strobe = 1'b0;
            exp_ctl = 2'b00;
        end else begin
            rv = ref_enc(m_d2);
            rc = m_d2[14:13];
            m_d2 = m_d1;
            m_d1 = k;
            if (rv == m_last) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_last = rv;
                m_run = 1;
            end
            exp_strobe = 1'b0;
            if (m_run >= D + 1 && rv != m_stable) begin
                m_stable = rv;
                exp_strobe = (rv != 4'd0);
            end
            for (int j = 0; j < 2; j++) begin
                exp_ctl[j] = 1'b0;
                if (rc[j] == c_last[j]) begin
                    if (c_run[j] < 1000) c_run[j]++;
                end else begin
                    c_last[j] = rc[j];
                    c_run[j] = 1;
                end
                if (c_run[j] >= D + 1 && rc[j] != c_stable[j]) begin
                    c_stable[j] = rc[j];
                    exp_ctl[j] = rc[j];
                end
            end
        end
        exp_keycode = m_stable;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the model, then compare 1 ns after the edge.
    task automatic step(input logic [14:0] k, input logic r);
        keypad_i = k;
        reset = r;
        @(posedge clk);
        model_edge(k, r);
        #1;
        check("keycode", {4'd0, keycode}, {4'd0, exp_keycode});
        check("note_strobe", {7'd0, note_strobe}, {7'd0, exp_strobe});
        check("mode_key", {7'd0, mode_key}, {7'd0, exp_ctl[0]});
        check("series_key", {7'd0, series_key}, {7'd0, exp_ctl[1]});
        if (note_strobe === 1'b1) n_strobe++;
        if (mode_key === 1'b1) n_mode++;
        if (series_key === 1'b1) n_series++;
        if (mode_key === 1'b1 && series_key === 1'b1) n_both++;
    endtask

    task automatic clear_counts();
        n_strobe = 0;
        n_mode = 0;
        n_series = 0;
        n_both = 0;
    endtask

    initial begin
        logic [14:0] k;
        logic [14:0] mask;
        int dur;

        keypad_i = 15'd0;
        reset = 1'b1;

        // Reset held for 3 cycles with key 0 pressed; the model expects all zeros.
        for (int i = 0; i < 3; i++) step(15'h0001, 1'b1);
        clear_counts();
        for (int i = 1; i <= 9; i++) begin
            step(15'h0001, 1'b0);
            if (i == 6) check("rst_pre_keycode", {4'd0, keycode}, 8'd0);
            if (i == 7) check("rst_rel_keycode", {4'd0, keycode}, 8'd1);
        end
        check("rst_strobe_count", 8'(n_strobe), 8'd1);

        // Release, then a clean press of key 4.
        for (int i = 0; i < 10; i++) step(15'h0000, 1'b0);
        clear_counts();
        for (int i = 1; i <= 10; i++) begin
            step(15'h0010, 1'b0);
            if (i == 6) check("press_pre_keycode", {4'd0, keycode}, 8'd0);
            if (i == 7) begin
                check("press_keycode", {4'd0, keycode}, 8'd5);
                check("press_strobe", {7'd0, note_strobe}, 8'd1);
            end
        end
        check("press_strobe_count", 8'(n_strobe), 8'd1);

        // Release; the note is debounced out and no strobe follows.
        clear_counts();
        for (int i = 1; i <= 10; i++) begin
            step(15'h0000, 1'b0);
            if (i == 6) check("rel_pre_keycode", {4'd0, keycode}, 8'd5);
            if (i == 7) check("rel_keycode", {4'd0, keycode}, 8'd0);
        end
        check("rel_strobe_count", 8'(n_strobe), 8'd0);

        // Bounce on bit 2 (1,0,1,0,1), then hold.
        // The final transition is edge 1 of the hold.
        clear_counts();
        step(15'h0004, 1'b0);
        step(15'h0000, 1'b0);
        step(15'h0004, 1'b0);
        step(15'h0000, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            step(15'h0004, 1'b0);
            if (i == 6) check("bounce_pre_keycode", {4'd0, keycode}, 8'd0);
            if (i == 7) check("bounce_keycode", {4'd0, keycode}, 8'd3);
        end
        check("bounce_strobe_count", 8'(n_strobe), 8'd1);

        // Priority (two keys held, the lower index wins), then a direct
        // note-to-note change with a second strobe.
        for (int i = 0; i < 10; i++) step(15'h0000, 1'b0);
        clear_counts();
        for (int i = 0; i < 10; i++) step(15'h0006, 1'b0);
        check("prio_keycode", {4'd0, keycode}, 8'd2);
        for (int i = 0; i < 10; i++) step(15'h0004, 1'b0);
        check("n2n_keycode", {4'd0, keycode}, 8'd3);
        check("n2n_strobe_count", 8'(n_strobe), 8'd2);

        // Both control keys pressed together and held for 20 cycles.
        for (int i = 0; i < 10; i++) step(15'h0000, 1'b0);
        clear_counts();
        for (int i = 1; i <= 20; i++) begin
            step(15'h6000, 1'b0);
            if (i == 7) check("ctl_same_cycle", {6'd0, mode_key, series_key}, 8'd3);
        end
        check("ctl_mode_count", 8'(n_mode), 8'd1);
        check("ctl_series_count", 8'(n_series), 8'd1);
        check("ctl_both_count", 8'(n_both), 8'd1);
        check("ctl_keycode", {4'd0, keycode}, 8'd0);
        for (int i = 0; i < 10; i++) step(15'h0000, 1'b0);
        check("ctl_release_count", 8'(n_mode + n_series), 8'd2);

        // Reset asserted on edge 5 of a debounce; the count restarts from zero.
        clear_counts();
        for (int i = 0; i < 4; i++) step(15'h0001, 1'b0);
        step(15'h0001, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            step(15'h0001, 1'b0);
            if (i == 6) check("midrst_pre_keycode", {4'd0, keycode}, 8'd0);
            if (i == 7) check("midrst_keycode", {4'd0, keycode}, 8'd1);
        end
        check("midrst_strobe_count", 8'(n_strobe), 8'd1);

        // Random segments checked against the model on every cycle.
        for (int s = 0; s < 150; s++) begin
            case ($urandom_range(0, 3))
                0: mask = 15'h7FFF;
                1: mask = 15'h001F;
                2: mask = 15'h6000;
                default: mask = 15'h0000;
            endcase
            k = 15'($urandom) & mask;
            dur = $urandom_range(1, 9);
            for (int i = 0; i < dur; i++) begin
                step(k, ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
